free_list: RTL and testbench

- Physical-register free list for the out-of-order core. It sits directly upstream of rename and supplies the destination physical register (prd) for every renamed instruction that writes a register.
- Registers are returned at retirement, when the previous mapping of a destination becomes dead.
- A committed-head pointer lets a pipeline flush restore the list to its architectural state in one cycle.

---
 rtl/free_list_if.sv | 25 ++
 rtl/free_list.sv | 70 +++++++
 tb/tb_free_list.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Rename-side and retirement-side signals of the physical-register free list.
interface free_list_if #(
  parameter int unsigned PREG_W = 6,
  parameter int unsigned PTR_W  = 6
);
  logic              alloc_req_i;
  logic              alloc_valid_o;
  logic [PREG_W-1:0] alloc_preg_o;
  logic              free_en_i;
  logic [PREG_W-1:0] free_preg_i;
  logic              commit_alloc_i;
  logic              flush_i;
  logic [PTR_W-1:0]  free_count_o;
  logic              overflow_err_o;

  modport slave (
    input  alloc_req_i, free_en_i, free_preg_i, commit_alloc_i, flush_i,
    output alloc_valid_o, alloc_preg_o, free_count_o, overflow_err_o
  );

  modport master (
    output alloc_req_i, free_en_i, free_preg_i, commit_alloc_i, flush_i,
    input  alloc_valid_o, alloc_preg_o, free_count_o, overflow_err_o
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular buffer with speculative head, committed
// head for single-cycle flush recovery, and a tail fed by retirement.
module free_list #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned PREG_W    = 6
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  free_list_if.slave   fl
);
  localparam int unsigned DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [PREG_W-1:0] r_entry [DEPTH];
  logic [PTR_W-1:0]  r_spec_head;
  logic [PTR_W-1:0]  r_commit_head;
  logic [PTR_W-1:0]  r_tail;
  logic              r_overflow;

  logic [PTR_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_alloc;
  logic              w_free;
  logic              w_commit;
  logic [PTR_W-1:0]  w_commit_next;
  logic [PTR_W-1:0]  w_spec_next;

  always_comb begin
    w_count       = r_tail - r_spec_head;
    w_full        = (w_count == PTR_W'(DEPTH));
    w_empty       = (w_count == '0);
    w_alloc       = fl.alloc_req_i && !w_empty && !fl.flush_i;
    w_free        = fl.free_en_i && (fl.free_preg_i != '0) && !w_full;
    // Commit may never overtake the speculative head.
    w_commit      = fl.commit_alloc_i && (r_commit_head != r_spec_head);
    w_commit_next = r_commit_head + PTR_W'(w_commit);
    // Flush restores the head using the commit applied in the same cycle.
    w_spec_next   = fl.flush_i ? w_commit_next : (r_spec_head + PTR_W'(w_alloc));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_entry[i] <= PREG_W'(NUM_AREGS + i);
      end
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= PTR_W'(DEPTH);
      r_overflow    <= 1'b0;
    end else begin
      if (w_free) begin
        r_entry[r_tail[IDX_W-1:0]] <= fl.free_preg_i;
      end
      r_tail        <= r_tail + PTR_W'(w_free);
      r_spec_head   <= w_spec_next;
      r_commit_head <= w_commit_next;
      if (fl.free_en_i && (fl.free_preg_i != '0) && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign fl.alloc_valid_o  = !w_empty;
  assign fl.alloc_preg_o   = r_entry[r_spec_head[IDX_W-1:0]];
  assign fl.free_count_o   = w_count;
  assign fl.overflow_err_o = r_overflow;
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list; wrap test compares against a queue model.
module tb_free_list;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  int   errors = 0;
  int   checks = 0;

  free_list_if #(.PREG_W(6), .PTR_W(6)) fl ();

  free_list #(.NUM_PREGS(64), .NUM_AREGS(32), .PREG_W(6)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .fl       (fl)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    fl.alloc_req_i    = 1'b0;
    fl.free_en_i      = 1'b0;
    fl.free_preg_i    = '0;
    fl.commit_alloc_i = 1'b0;
    fl.flush_i        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk_i);
    reset_ni = 1'b0;
    #2;
    reset_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fl.alloc_valid_o !== 1'b1) begin errors++; $display("FAIL reset_valid: got %0d expected 1", fl.alloc_valid_o); end
    checks++; if (fl.alloc_preg_o !== 6'd32) begin errors++; $display("FAIL reset_preg: got %0d expected 32", fl.alloc_preg_o); end
    checks++; if (fl.free_count_o !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d expected 32", fl.free_count_o); end
    checks++; if (fl.overflow_err_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", fl.overflow_err_o); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      checks++; if (fl.alloc_preg_o !== 6'(32 + i)) begin errors++; $display("FAIL drain_preg[%0d]: got %0d expected %0d", i, fl.alloc_preg_o, 32 + i); end
      checks++; if (fl.free_count_o !== 6'(32 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, fl.free_count_o, 32 - i); end
      fl.alloc_req_i = 1'b1;
      tick();
    end
    checks++; if (fl.alloc_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %0d expected 0", fl.alloc_valid_o); end
    checks++; if (fl.free_count_o !== 6'd0) begin errors++; $display("FAIL drain_empty_count: got %0d expected 0", fl.free_count_o); end
    tick();
    fl.alloc_req_i = 1'b0;
    checks++; if (fl.free_count_o !== 6'd0) begin errors++; $display("FAIL empty_alloc_count: got %0d expected 0", fl.free_count_o); end
  endtask

  // Continues from the empty state left by test_drain.
  task automatic test_free_visibility();
    fl.free_en_i   = 1'b1;
    fl.free_preg_i = 6'd40;
    #1;
    checks++; if (fl.alloc_valid_o !== 1'b0) begin errors++; $display("FAIL nobypass_valid: got %0d expected 0", fl.alloc_valid_o); end
    tick();
    fl.free_preg_i = 6'd0;
    checks++; if (fl.alloc_valid_o !== 1'b1) begin errors++; $display("FAIL freed_valid: got %0d expected 1", fl.alloc_valid_o); end
    checks++; if (fl.alloc_preg_o !== 6'd40) begin errors++; $display("FAIL freed_preg: got %0d expected 40", fl.alloc_preg_o); end
    checks++; if (fl.free_count_o !== 6'd1) begin errors++; $display("FAIL freed_count: got %0d expected 1", fl.free_count_o); end
    tick();
    fl.free_en_i = 1'b0;
    checks++; if (fl.free_count_o !== 6'd1) begin errors++; $display("FAIL free_x0_count: got %0d expected 1", fl.free_count_o); end
    checks++; if (fl.alloc_preg_o !== 6'd40) begin errors++; $display("FAIL free_x0_preg: got %0d expected 40", fl.alloc_preg_o); end
  endtask

  task automatic test_flush();
    do_reset();
    fl.alloc_req_i = 1'b1;
    repeat (5) tick();
    fl.alloc_req_i    = 1'b0;
    fl.commit_alloc_i = 1'b1;
    repeat (2) tick();
    fl.commit_alloc_i = 1'b0;
    fl.flush_i        = 1'b1;
    tick();
    fl.flush_i = 1'b0;
    checks++; if (fl.alloc_preg_o !== 6'd34) begin errors++; $display("FAIL flush_preg: got %0d expected 34", fl.alloc_preg_o); end
    checks++; if (fl.free_count_o !== 6'd30) begin errors++; $display("FAIL flush_count: got %0d expected 30", fl.free_count_o); end

    // Commit, discarded alloc and accepted free all in the flush cycle.
    do_reset();
    fl.alloc_req_i = 1'b1;
    repeat (5) tick();
    fl.alloc_req_i    = 1'b0;
    fl.commit_alloc_i = 1'b1;
    repeat (2) tick();
    fl.flush_i     = 1'b1;
    fl.alloc_req_i = 1'b1;
    fl.free_en_i   = 1'b1;
    fl.free_preg_i = 6'd50;
    tick();
    idle_inputs();
    checks++; if (fl.alloc_preg_o !== 6'd35) begin errors++; $display("FAIL flush_commit_preg: got %0d expected 35", fl.alloc_preg_o); end
    checks++; if (fl.free_count_o !== 6'd30) begin errors++; $display("FAIL flush_commit_count: got %0d expected 30", fl.free_count_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    fl.free_en_i   = 1'b1;
    fl.free_preg_i = 6'd7;
    tick();
    idle_inputs();
    checks++; if (fl.free_count_o !== 6'd32) begin errors++; $display("FAIL ovf_count: got %0d expected 32", fl.free_count_o); end
    checks++; if (fl.overflow_err_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0d expected 1", fl.overflow_err_o); end
    fl.alloc_req_i = 1'b1;
    repeat (3) tick();
    fl.alloc_req_i = 1'b0;
    checks++; if (fl.overflow_err_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0d expected 1", fl.overflow_err_o); end
    checks++; if (fl.alloc_preg_o !== 6'd35) begin errors++; $display("FAIL ovf_head: got %0d expected 35", fl.alloc_preg_o); end
    #2;
    reset_ni = 1'b0;
    #1;
    checks++; if (fl.overflow_err_o !== 1'b0) begin errors++; $display("FAIL async_rst_ovf: got %0d expected 0", fl.overflow_err_o); end
    checks++; if (fl.alloc_preg_o !== 6'd32) begin errors++; $display("FAIL async_rst_preg: got %0d expected 32", fl.alloc_preg_o); end
    checks++; if (fl.free_count_o !== 6'd32) begin errors++; $display("FAIL async_rst_count: got %0d expected 32", fl.free_count_o); end
    reset_ni = 1'b1;
  endtask

  task automatic test_wrap();
    int q[$];
    logic req, fen, a_ok, f_ok;
    logic [5:0] p;
    do_reset();
    fl.alloc_req_i = 1'b1;
    repeat (31) tick();
    checks++; if (fl.alloc_preg_o !== 6'd63) begin errors++; $display("FAIL one_left_preg: got %0d expected 63", fl.alloc_preg_o); end
    checks++; if (fl.free_count_o !== 6'd1) begin errors++; $display("FAIL one_left_count: got %0d expected 1", fl.free_count_o); end
    fl.free_en_i   = 1'b1;
    fl.free_preg_i = 6'd45;
    tick();
    idle_inputs();
    checks++; if (fl.free_count_o !== 6'd1) begin errors++; $display("FAIL simul_count: got %0d expected 1", fl.free_count_o); end
    checks++; if (fl.alloc_preg_o !== 6'd45) begin errors++; $display("FAIL simul_preg: got %0d expected 45", fl.alloc_preg_o); end
    q.push_back(45);
    for (int c = 0; c < 100; c++) begin
      req = 1'($urandom_range(0, 1));
      fen = 1'($urandom_range(0, 1));
      p   = 6'($urandom_range(0, 63));
      fl.alloc_req_i = req;
      fl.free_en_i   = fen;
      fl.free_preg_i = p;
      #1;
      checks++; if (fl.free_count_o !== 6'(q.size())) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", c, fl.free_count_o, q.size()); end
      checks++; if (fl.alloc_valid_o !== (q.size() != 0)) begin errors++; $display("FAIL wrap_valid[%0d]: got %0d expected %0d", c, fl.alloc_valid_o, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (fl.alloc_preg_o !== 6'(q[0])) begin errors++; $display("FAIL wrap_preg[%0d]: got %0d expected %0d", c, fl.alloc_preg_o, q[0]); end
      end
      a_ok = req && (q.size() != 0);
      f_ok = fen && (p != 6'd0) && (q.size() != 32);
      tick();
      if (a_ok) void'(q.pop_front());
      if (f_ok) q.push_back(int'(p));
    end
    idle_inputs();
    checks++; if (fl.free_count_o !== 6'(q.size())) begin errors++; $display("FAIL wrap_final_count: got %0d expected %0d", fl.free_count_o, q.size()); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_drain();
    test_free_visibility();
    test_flush();
    test_overflow();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
